// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA layer engine: rectangle config record,
// the fixed 16-entry 4:4:4 palette and default 640x480@60 timing.
package vga_pkg;

    localparam int RECT_COORD_W = 16;

    typedef struct packed {
        logic                    en;
        logic [RECT_COORD_W-1:0] x_start;
        logic [RECT_COORD_W-1:0] x_end;
        logic [RECT_COORD_W-1:0] y_start;
        logic [RECT_COORD_W-1:0] y_end;
        logic [3:0]              color;
    } rect_cfg_t;

    localparam logic [11:0] PALETTE [16] = '{
        12'h000, 12'hF00, 12'h0F0, 12'h00F, 12'hFF0, 12'h0FF, 12'hF0F, 12'hFFF,
        12'h888, 12'h800, 12'h080, 12'h008, 12'h880, 12'h088, 12'h808, 12'h444
    };

    function automatic logic [11:0] palette_lookup(input logic [3:0] idx);
        return PALETTE[idx];
    endfunction

    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BACK   = 48;
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FRONT  = 16;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BACK   = 33;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FRONT  = 10;

endpackage

// File: rtl/vga_timing.sv
// Pixel clock-enable divider, raster counters and the combinational decode of
// sync, active area, active-area coordinates and the last-pixel-of-frame strobe.
module vga_timing #(
    parameter int CLK_DIV  = 2,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int COORD_W  = 10
) (
    input  logic               sys_clk,
    input  logic               rst_n,
    output logic               pix_ce,
    output logic               h_sync_on,
    output logic               v_sync_on,
    output logic               active,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               frame_end
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int H_BEG   = H_SYNC + H_BACK;
    localparam int H_END   = H_BEG + H_ACTIVE;
    localparam int V_BEG   = V_SYNC + V_BACK;
    localparam int V_END   = V_BEG + V_ACTIVE;
    localparam int H_W     = $clog2(H_TOTAL + 1);
    localparam int V_W     = $clog2(V_TOTAL + 1);
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic [H_W-1:0]   h_cnt;
    logic [V_W-1:0]   v_cnt;
    logic             h_last;
    logic             v_last;
    logic             h_act;
    logic             v_act;

    // With CLK_DIV = 1 the counter never leaves 0, so pix_ce is held high.
    assign pix_ce = (div_cnt == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge sys_clk or posedge rst_n) begin
        if (rst_n) begin
            div_cnt <= '0;
        end else if (pix_ce) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign h_last = (h_cnt == H_W'(H_TOTAL - 1));
    assign v_last = (v_cnt == V_W'(V_TOTAL - 1));

    always_ff @(posedge sys_clk or posedge rst_n) begin
        if (rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_ce) begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? '0 : v_cnt + V_W'(1);
            end else begin
                h_cnt <= h_cnt + H_W'(1);
            end
        end
    end

    assign h_sync_on = (h_cnt < H_W'(H_SYNC));
    assign v_sync_on = (v_cnt < V_W'(V_SYNC));
    assign h_act     = (h_cnt >= H_W'(H_BEG)) && (h_cnt < H_W'(H_END));
    assign v_act     = (v_cnt >= V_W'(V_BEG)) && (v_cnt < V_W'(V_END));
    assign active    = h_act && v_act;
    assign x         = active ? COORD_W'(h_cnt - H_W'(H_BEG)) : '0;
    assign y         = active ? COORD_W'(v_cnt - V_W'(V_BEG)) : '0;
    assign frame_end = pix_ce && h_last && v_last;

endmodule

// File: rtl/vga_layer_engine.sv
// VGA raster generator compositing N_RECT filled rectangles over a background;
// rectangle configs are double-buffered and swapped at the frame boundary.
module vga_layer_engine
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BACK   = VGA_H_BACK,
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FRONT  = VGA_H_FRONT,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BACK   = VGA_V_BACK,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FRONT  = VGA_V_FRONT,
    parameter int SYNC_POL = 0,
    parameter int N_RECT   = 4,
    parameter int COORD_W  = 10
) (
    input  logic               sys_clk,
    input  logic               rst_n,
    input  logic               cfg_wr,
    input  logic [3:0]         cfg_idx,
    input  logic               cfg_en,
    input  logic [COORD_W-1:0] cfg_x_start,
    input  logic [COORD_W-1:0] cfg_x_end,
    input  logic [COORD_W-1:0] cfg_y_start,
    input  logic [COORD_W-1:0] cfg_y_end,
    input  logic [3:0]         cfg_color,
    input  logic [11:0]        bg_rgb,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic [11:0]        rgb,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               frame_start
);

    localparam logic SYNC_ON = 1'(SYNC_POL);

    logic               pix_ce;
    logic               t_hs;
    logic               t_vs;
    logic               t_act;
    logic [COORD_W-1:0] t_x;
    logic [COORD_W-1:0] t_y;
    logic               frame_end;

    vga_timing #(
        .CLK_DIV  (CLK_DIV),
        .H_SYNC   (H_SYNC),
        .H_BACK   (H_BACK),
        .H_ACTIVE (H_ACTIVE),
        .H_FRONT  (H_FRONT),
        .V_SYNC   (V_SYNC),
        .V_BACK   (V_BACK),
        .V_ACTIVE (V_ACTIVE),
        .V_FRONT  (V_FRONT),
        .COORD_W  (COORD_W)
    ) u_timing (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .pix_ce    (pix_ce),
        .h_sync_on (t_hs),
        .v_sync_on (t_vs),
        .active    (t_act),
        .x         (t_x),
        .y         (t_y),
        .frame_end (frame_end)
    );

    rect_cfg_t pending [N_RECT];
    rect_cfg_t shadow  [N_RECT];
    rect_cfg_t new_cfg;

    always_comb begin
        new_cfg         = '0;
        new_cfg.en      = cfg_en;
        new_cfg.x_start = RECT_COORD_W'(cfg_x_start);
        new_cfg.x_end   = RECT_COORD_W'(cfg_x_end);
        new_cfg.y_start = RECT_COORD_W'(cfg_y_start);
        new_cfg.y_end   = RECT_COORD_W'(cfg_y_end);
        new_cfg.color   = cfg_color;
    end

    // Shadow copies the pre-write pending value, so a write landing on the
    // commit edge is held back until the following frame.
    always_ff @(posedge sys_clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < N_RECT; i++) begin
                pending[i] <= '0;
                shadow[i]  <= '0;
            end
            frame_start <= 1'b0;
        end else begin
            frame_start <= frame_end;
            if (frame_end) begin
                for (int i = 0; i < N_RECT; i++) shadow[i] <= pending[i];
            end
            if (cfg_wr) begin
                for (int i = 0; i < N_RECT; i++) begin
                    if (cfg_idx == 4'(i)) pending[i] <= new_cfg;
                end
            end
        end
    end

    logic               s1_hs;
    logic               s1_vs;
    logic               s1_act;
    logic [COORD_W-1:0] s1_x;
    logic [COORD_W-1:0] s1_y;

    always_ff @(posedge sys_clk or posedge rst_n) begin
        if (rst_n) begin
            s1_hs  <= 1'b0;
            s1_vs  <= 1'b0;
            s1_act <= 1'b0;
            s1_x   <= '0;
            s1_y   <= '0;
        end else if (pix_ce) begin
            s1_hs  <= t_hs;
            s1_vs  <= t_vs;
            s1_act <= t_act;
            s1_x   <= t_x;
            s1_y   <= t_y;
        end
    end

    // Inverted ranges need no special case: start <= p <= end can never hold.
    function automatic logic layer_hit(input rect_cfg_t c,
                                       input logic [RECT_COORD_W-1:0] px,
                                       input logic [RECT_COORD_W-1:0] py);
        return c.en && (c.x_start <= px) && (px <= c.x_end)
                    && (c.y_start <= py) && (py <= c.y_end);
    endfunction

    logic [11:0] mix_rgb;

    always_comb begin
        mix_rgb = bg_rgb;
        for (int i = N_RECT - 1; i >= 0; i--) begin
            if (layer_hit(shadow[i], RECT_COORD_W'(s1_x), RECT_COORD_W'(s1_y)))
                mix_rgb = palette_lookup(shadow[i].color);
        end
    end

    always_ff @(posedge sys_clk or posedge rst_n) begin
        if (rst_n) begin
            hsync <= ~SYNC_ON;
            vsync <= ~SYNC_ON;
            de    <= 1'b0;
            rgb   <= '0;
            pix_x <= '0;
            pix_y <= '0;
        end else if (pix_ce) begin
            hsync <= s1_hs ? SYNC_ON : ~SYNC_ON;
            vsync <= s1_vs ? SYNC_ON : ~SYNC_ON;
            de    <= s1_act;
            rgb   <= s1_act ? mix_rgb : 12'h000;
            pix_x <= s1_x;
            pix_y <= s1_y;
        end
    end

endmodule

// File: tb/tb_vga_layer_engine.sv
// Bench for vga_layer_engine: a shrunken-raster instance for compositing and
// commit behaviour, plus a default-raster CLK_DIV=1 / active-high-sync instance.
module tb_vga_layer_engine;

    localparam int CLK_DIV  = 2;
    localparam int H_SYNC   = 4;
    localparam int H_BACK   = 3;
    localparam int H_ACTIVE = 40;
    localparam int H_FRONT  = 2;
    localparam int V_SYNC   = 2;
    localparam int V_BACK   = 2;
    localparam int V_ACTIVE = 32;
    localparam int V_FRONT  = 2;
    localparam int N_RECT   = 4;
    localparam int COORD_W  = 10;
    localparam int LINE_CLKS  = (H_SYNC + H_BACK + H_ACTIVE + H_FRONT) * CLK_DIV;
    localparam int FRAME_CLKS = LINE_CLKS * (V_SYNC + V_BACK + V_ACTIVE + V_FRONT);
    localparam int BUDGET     = 5000;

    localparam logic [11:0] PAL [16] = '{
        12'h000, 12'hF00, 12'h0F0, 12'h00F, 12'hFF0, 12'h0FF, 12'hF0F, 12'hFFF,
        12'h888, 12'h800, 12'h080, 12'h008, 12'h880, 12'h088, 12'h808, 12'h444
    };

    logic               sys_clk = 1'b0;
    logic               rst_n   = 1'b1;
    logic               cfg_wr  = 1'b0;
    logic [3:0]         cfg_idx = '0;
    logic               cfg_en  = 1'b0;
    logic [COORD_W-1:0] cfg_x_start = '0;
    logic [COORD_W-1:0] cfg_x_end   = '0;
    logic [COORD_W-1:0] cfg_y_start = '0;
    logic [COORD_W-1:0] cfg_y_end   = '0;
    logic [3:0]         cfg_color   = '0;
    logic [11:0]        bg_rgb      = 12'h1A5;

    logic               hsync, vsync, de, frame_start;
    logic [11:0]        rgb;
    logic [COORD_W-1:0] pix_x, pix_y;

    logic               f_hsync, f_vsync, f_de, f_frame_start;
    logic [11:0]        f_rgb;
    logic [COORD_W-1:0] f_pix_x, f_pix_y;

    int n_checks  = 0;
    int n_errors  = 0;
    int blank_bad = 0;

    logic [11:0]        exp_q [$];
    logic [COORD_W-1:0] px_q  [$];
    logic [COORD_W-1:0] py_q  [$];

    always #5 sys_clk = ~sys_clk;

    vga_layer_engine #(
        .CLK_DIV (CLK_DIV), .H_SYNC (H_SYNC), .H_BACK (H_BACK), .H_ACTIVE (H_ACTIVE),
        .H_FRONT (H_FRONT), .V_SYNC (V_SYNC), .V_BACK (V_BACK), .V_ACTIVE (V_ACTIVE),
        .V_FRONT (V_FRONT), .SYNC_POL (0), .N_RECT (N_RECT), .COORD_W (COORD_W)
    ) dut (
        .sys_clk (sys_clk), .rst_n (rst_n), .cfg_wr (cfg_wr), .cfg_idx (cfg_idx),
        .cfg_en (cfg_en), .cfg_x_start (cfg_x_start), .cfg_x_end (cfg_x_end),
        .cfg_y_start (cfg_y_start), .cfg_y_end (cfg_y_end), .cfg_color (cfg_color),
        .bg_rgb (bg_rgb), .hsync (hsync), .vsync (vsync), .de (de), .rgb (rgb),
        .pix_x (pix_x), .pix_y (pix_y), .frame_start (frame_start)
    );

    vga_layer_engine #(
        .CLK_DIV (1), .SYNC_POL (1)
    ) dut_fast (
        .sys_clk (sys_clk), .rst_n (rst_n), .cfg_wr (1'b0), .cfg_idx (4'h0),
        .cfg_en (1'b0), .cfg_x_start (10'd0), .cfg_x_end (10'd0),
        .cfg_y_start (10'd0), .cfg_y_end (10'd0), .cfg_color (4'h0),
        .bg_rgb (12'h123), .hsync (f_hsync), .vsync (f_vsync), .de (f_de), .rgb (f_rgb),
        .pix_x (f_pix_x), .pix_y (f_pix_y), .frame_start (f_frame_start)
    );

    // Pixel scoreboard: probes are queued in raster order and consumed when
    // the DUT presents the matching coordinate.
    always @(negedge sys_clk) begin
        if (!rst_n) begin
            if (de === 1'b0 && (rgb !== 12'h000 || pix_x !== '0 || pix_y !== '0))
                blank_bad++;
            if (exp_q.size() > 0 && de === 1'b1 && pix_x === px_q[0] && pix_y === py_q[0]) begin
                n_checks++;
                if (rgb !== exp_q[0]) begin
                    n_errors++;
                    $display("FAIL pixel(%0d,%0d): rgb=%h expected %h", pix_x, pix_y, rgb, exp_q[0]);
                end
                void'(exp_q.pop_front());
                void'(px_q.pop_front());
                void'(py_q.pop_front());
            end
        end
    end

    task automatic push_probe(input int x, input int y, input logic [11:0] c);
        px_q.push_back(COORD_W'(x));
        py_q.push_back(COORD_W'(y));
        exp_q.push_back(c);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < BUDGET && exp_q.size() > 0; i++) @(negedge sys_clk);
        n_checks++;
        if (exp_q.size() > 0) begin
            n_errors++;
            $display("FAIL %s: %0d probes never reached, expected 0 left", name, exp_q.size());
            exp_q.delete();
            px_q.delete();
            py_q.delete();
        end
    endtask

    task automatic wait_frame_start(input string name);
        bit seen = 0;
        for (int i = 0; i < BUDGET && !seen; i++) begin
            @(negedge sys_clk);
            if (frame_start === 1'b1) seen = 1;
        end
        if (!seen) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: frame_start=0 after %0d cycles, expected a pulse", name, BUDGET);
        end
    endtask

    task automatic write_rect(input int idx, input bit en, input int xs, input int xe,
                              input int ys, input int ye, input int col);
        cfg_idx     = 4'(idx);
        cfg_en      = en;
        cfg_x_start = COORD_W'(xs);
        cfg_x_end   = COORD_W'(xe);
        cfg_y_start = COORD_W'(ys);
        cfg_y_end   = COORD_W'(ye);
        cfg_color   = 4'(col);
        cfg_wr      = 1'b1;
        @(negedge sys_clk);
        cfg_wr      = 1'b0;
    endtask

    task automatic test_reset();
        int  n_slow = 0;
        int  n_fast = 0;
        bit  seen = 0;
        rst_n = 1'b1;
        repeat (5) @(negedge sys_clk);
        n_checks += 7;
        if (hsync !== 1'b1) begin n_errors++; $display("FAIL reset_hsync: %b expected 1", hsync); end
        if (vsync !== 1'b1) begin n_errors++; $display("FAIL reset_vsync: %b expected 1", vsync); end
        if (de !== 1'b0 || rgb !== 12'h000) begin
            n_errors++; $display("FAIL reset_de_rgb: de=%b rgb=%h expected 0/000", de, rgb);
        end
        if (pix_x !== '0 || pix_y !== '0) begin
            n_errors++; $display("FAIL reset_xy: %0d,%0d expected 0,0", pix_x, pix_y);
        end
        if (frame_start !== 1'b0) begin
            n_errors++; $display("FAIL reset_frame_start: %b expected 0", frame_start);
        end
        if (f_hsync !== 1'b0 || f_vsync !== 1'b0) begin
            n_errors++; $display("FAIL reset_fast_sync: %b%b expected 00", f_hsync, f_vsync);
        end
        if (f_de !== 1'b0 || f_rgb !== 12'h000 || f_pix_x !== '0 || f_pix_y !== '0 || f_frame_start !== 1'b0) begin
            n_errors++; $display("FAIL reset_fast_outputs: de=%b rgb=%h fs=%b expected all 0", f_de, f_rgb, f_frame_start);
        end

        rst_n = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge sys_clk);
            if (n_slow == 0 && hsync === 1'b0) n_slow = n;
            if (n_fast == 0 && f_hsync === 1'b1) n_fast = n;
        end
        n_checks += 2;
        if (n_slow != 4) begin n_errors++; $display("FAIL release_latency: %0d cycles expected 4", n_slow); end
        if (n_fast != 2) begin n_errors++; $display("FAIL release_latency_fast: %0d cycles expected 2", n_fast); end

        for (int i = 0; i < BUDGET && !seen; i++) begin
            @(negedge sys_clk);
            if (de === 1'b1) seen = 1;
        end
        #2 rst_n = 1'b1;
        #1;
        n_checks++;
        if (!seen || de !== 1'b0 || rgb !== 12'h000 || hsync !== 1'b1 || pix_x !== '0) begin
            n_errors++;
            $display("FAIL async_reset: seen_de=%b de=%b rgb=%h hsync=%b x=%0d expected 1/0/000/1/0",
                     seen, de, rgb, hsync, pix_x);
        end
        @(negedge sys_clk);
        rst_n = 1'b0;
    endtask

    task automatic test_timing();
        bit prev;
        bit found = 0;
        int period = 0, hs_low = 1, de_high = 0, de_first = 0;
        int vs_low = 1, fs_cnt = 0, fperiod = 0;
        for (int i = 0; i < BUDGET && !found; i++) begin
            @(negedge sys_clk);
            if (de === 1'b1 && pix_y == COORD_W'(5)) found = 1;
        end
        prev = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge sys_clk);
            if (hsync === 1'b0 && prev === 1'b1) break;
            prev = hsync;
        end
        prev = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge sys_clk);
            if (hsync === 1'b0 && prev === 1'b1) begin period = c; break; end
            prev = hsync;
            if (hsync === 1'b0) hs_low++;
            if (de === 1'b1) begin
                de_high++;
                if (de_first == 0) de_first = c;
            end
        end
        n_checks += 4;
        if (period != LINE_CLKS) begin n_errors++; $display("FAIL line_period: %0d expected %0d", period, LINE_CLKS); end
        if (hs_low != H_SYNC * CLK_DIV) begin n_errors++; $display("FAIL hsync_width: %0d expected %0d", hs_low, H_SYNC * CLK_DIV); end
        if (de_high != H_ACTIVE * CLK_DIV) begin n_errors++; $display("FAIL de_width: %0d expected %0d", de_high, H_ACTIVE * CLK_DIV); end
        if (de_first != (H_SYNC + H_BACK) * CLK_DIV) begin
            n_errors++; $display("FAIL de_offset: %0d expected %0d", de_first, (H_SYNC + H_BACK) * CLK_DIV);
        end

        prev = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge sys_clk);
            if (vsync === 1'b0 && prev === 1'b1) break;
            prev = vsync;
        end
        prev = 1'b0;
        for (int c = 1; c <= FRAME_CLKS + 100; c++) begin
            @(negedge sys_clk);
            if (vsync === 1'b0 && prev === 1'b1) begin fperiod = c; break; end
            prev = vsync;
            if (vsync === 1'b0) vs_low++;
            if (frame_start === 1'b1) fs_cnt++;
        end
        n_checks += 3;
        if (fperiod != FRAME_CLKS) begin n_errors++; $display("FAIL frame_period: %0d expected %0d", fperiod, FRAME_CLKS); end
        if (vs_low != V_SYNC * LINE_CLKS) begin n_errors++; $display("FAIL vsync_width: %0d expected %0d", vs_low, V_SYNC * LINE_CLKS); end
        if (fs_cnt != 1) begin n_errors++; $display("FAIL frame_start_count: %0d expected 1", fs_cnt); end
    endtask

    task automatic test_priority();
        bg_rgb = {4'h1, 8'($urandom_range(0, 255))};
        write_rect(0, 1, 10, 20, 10, 20, 1);
        write_rect(1, 1, 15, 30, 15, 30, 2);
        wait_frame_start("priority_commit");
        push_probe(5, 5, bg_rgb);
        push_probe(12, 12, PAL[1]);
        push_probe(28, 16, PAL[2]);
        push_probe(17, 17, PAL[1]);
        push_probe(25, 25, PAL[2]);
        push_probe(35, 30, bg_rgb);
        drain("priority");
    endtask

    task automatic test_commit();
        bit found = 0;
        for (int i = 0; i < BUDGET && !found; i++) begin
            @(negedge sys_clk);
            if (de === 1'b1 && pix_y == COORD_W'(10)) found = 1;
        end
        write_rect(0, 1, 0, 39, 20, 25, 4);
        push_probe(17, 17, PAL[1]);
        push_probe(5, 22, bg_rgb);
        drain("commit_current_frame");
        wait_frame_start("commit_next");
        push_probe(17, 17, PAL[2]);
        push_probe(5, 22, PAL[4]);
        drain("commit_next_frame");
    endtask

    task automatic test_back_to_back();
        wait_frame_start("b2b_align");
        write_rect(0, 1, 0, 9, 0, 9, 5);
        push_probe(5, 5, bg_rgb);
        push_probe(5, 22, PAL[4]);
        drain("b2b_coincident_frame");
        write_rect(1, 1, 0, 39, 0, 31, 6);
        write_rect(1, 1, 30, 39, 0, 5, 7);
        wait_frame_start("b2b_next");
        push_probe(5, 5, PAL[5]);
        push_probe(20, 5, bg_rgb);
        push_probe(35, 5, PAL[7]);
        push_probe(5, 22, bg_rgb);
        push_probe(20, 28, bg_rgb);
        drain("b2b_next_frame");
    endtask

    task automatic test_degenerate();
        bg_rgb = {4'h1, 8'($urandom_range(0, 255))};
        write_rect(0, 0, 0, 9, 0, 9, 5);
        write_rect(1, 1, 0, 39, 20, 10, 6);
        write_rect(2, 1, 30, 20, 0, 31, 3);
        write_rect(N_RECT, 1, 0, 39, 0, 31, 6);
        wait_frame_start("degenerate_commit");
        push_probe(0, 0, bg_rgb);
        push_probe(25, 5, bg_rgb);
        push_probe(39, 15, bg_rgb);
        push_probe(25, 31, bg_rgb);
        drain("degenerate_no_hit");
        write_rect(3, 1, 0, 39, 0, 31, 7);
        wait_frame_start("fullscreen_commit");
        push_probe(0, 0, PAL[7]);
        push_probe(39, 0, PAL[7]);
        push_probe(25, 15, PAL[7]);
        push_probe(0, 31, PAL[7]);
        push_probe(39, 31, PAL[7]);
        drain("fullscreen");
    endtask

    task automatic test_fast_pol();
        bit prev = 1'b1;
        int period = 0, hs_high = 1;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge sys_clk);
            if (f_hsync === 1'b1 && prev === 1'b0) break;
            prev = f_hsync;
        end
        prev = 1'b1;
        for (int c = 1; c <= 1000; c++) begin
            @(negedge sys_clk);
            if (f_hsync === 1'b1 && prev === 1'b0) begin period = c; break; end
            prev = f_hsync;
            if (f_hsync === 1'b1) hs_high++;
        end
        n_checks += 2;
        if (period != 800) begin n_errors++; $display("FAIL fast_line_period: %0d expected 800", period); end
        if (hs_high != 96) begin n_errors++; $display("FAIL fast_hsync_width: %0d expected 96", hs_high); end
    endtask

    task automatic test_blanking();
        n_checks++;
        if (blank_bad != 0) begin
            n_errors++;
            $display("FAIL blank_outputs: %0d blank cycles with nonzero rgb/x/y, expected 0", blank_bad);
        end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_priority();
        test_commit();
        test_back_to_back();
        test_degenerate();
        test_fast_pol();
        test_blanking();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
